// File: rtl/filo_arbiter.sv
// Round-robin arbiter sharing one filo stack among NUM_REQ requesters.
// A shadow occupancy count settles empty pops and full pushes without touching the stack.
module filo_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 8,
  parameter int FILO_DEPTH = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req_push,
  input  logic [NUM_REQ-1:0]               req_pop,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
  output logic [NUM_REQ-1:0]               gnt,
  output logic [NUM_REQ-1:0]               resp_val,
  output logic                             resp_empty,
  output logic [DATA_WIDTH-1:0]            resp_data,
  output logic [$clog2(FILO_DEPTH+1)-1:0]  count,
  output logic                             stk_wr_en,
  output logic                             stk_rd_en,
  output logic [DATA_WIDTH-1:0]            stk_wr_data,
  input  logic                             stk_wr_ready,
  input  logic [DATA_WIDTH-1:0]            stk_rd_data,
  input  logic                             stk_rd_val
);
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(FILO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FILO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(NUM_REQ - 1);

  logic [NUM_REQ-1:0]    gnt_q, gnt_d, resp_val_q, resp_val_d, elig_s;
  logic [PTR_W-1:0]      ptr_q, ptr_d, win_s;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  wr_en_q, wr_en_d, rd_en_q, rd_en_d;
  logic                  pop_q, pop_d, pop_empty_q, pop_empty_d;
  logic                  resp_empty_q, resp_empty_d;
  logic                  full_s, found_s;
  logic                  stk_rd_val_unused;

  assign stk_rd_val_unused = stk_rd_val;

  // Eligibility and round-robin winner search starting at ptr_q.
  always_comb begin
    full_s  = (count_q == DEPTH_C) || !stk_wr_ready;
    found_s = 1'b0;
    win_s   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig_s[i] = !gnt_q[i] && (req_pop[i] || (req_push[i] && !full_s));
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found_s && elig_s[(int'(ptr_q) + k) % NUM_REQ]) begin
        found_s = 1'b1;
        win_s   = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Next-state: issue the winner's operation and stage its pop response.
  always_comb begin
    gnt_d        = '0;
    ptr_d        = ptr_q;
    count_d      = count_q;
    wr_en_d      = 1'b0;
    rd_en_d      = 1'b0;
    wr_data_d    = wr_data_q;
    pop_d        = 1'b0;
    pop_empty_d  = 1'b0;
    resp_val_d   = pop_q ? gnt_q : '0;
    resp_empty_d = pop_q && pop_empty_q;
    if (found_s) begin
      gnt_d[win_s] = 1'b1;
      ptr_d        = (win_s == LAST_C) ? '0 : win_s + PTR_W'(1);
      // Push wins over a simultaneous pop from the same requester.
      if (req_push[win_s] && !full_s) begin
        wr_en_d   = 1'b1;
        wr_data_d = req_data[int'(win_s)*DATA_WIDTH +: DATA_WIDTH];
        count_d   = count_q + CNT_W'(1);
      end else begin
        pop_d = 1'b1;
        if (count_q != '0) begin
          rd_en_d = 1'b1;
          count_d = count_q - CNT_W'(1);
        end else begin
          pop_empty_d = 1'b1;
        end
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // State registers with synchronous reset shared with the stack.
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_q        <= '0;
      ptr_q        <= '0;
      count_q      <= '0;
      wr_en_q      <= 1'b0;
      rd_en_q      <= 1'b0;
      wr_data_q    <= '0;
      pop_q        <= 1'b0;
      pop_empty_q  <= 1'b0;
      resp_val_q   <= '0;
      resp_empty_q <= 1'b0;
    end else begin
      gnt_q        <= gnt_d;
      ptr_q        <= ptr_d;
      count_q      <= count_d;
      wr_en_q      <= wr_en_d;
      rd_en_q      <= rd_en_d;
      wr_data_q    <= wr_data_d;
      pop_q        <= pop_d;
      pop_empty_q  <= pop_empty_d;
      resp_val_q   <= resp_val_d;
      resp_empty_q <= resp_empty_d;
    end
  end

  // Stack read data is forwarded only for a non-empty response.
  always_comb begin
    if ((resp_val_q != '0) && !resp_empty_q) begin
      resp_data = stk_rd_data;
    end else begin
      resp_data = '0;
    end
  end

  assign gnt         = gnt_q;
  assign resp_val    = resp_val_q;
  assign resp_empty  = resp_empty_q;
  assign count       = count_q;
  assign stk_wr_en   = wr_en_q;
  assign stk_rd_en   = rd_en_q;
  assign stk_wr_data = wr_data_q;
endmodule

// File: tb/tb_filo_arbiter.sv
// Scoreboard bench for filo_arbiter: a queue-based stack model predicts grants and
// pop responses; a negedge monitor compares the DUT against those expectations.
module tb_filo_arbiter;
  localparam int N  = 2;
  localparam int DW = 8;
  localparam int D  = 8;
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req_push, req_pop, gnt, resp_val;
  logic [N*DW-1:0] req_data;
  logic          resp_empty, stk_wr_en, stk_rd_en, stk_wr_ready, stk_rd_val;
  logic [DW-1:0] resp_data, stk_wr_data, stk_rd_data;
  logic [CW-1:0] count;
  logic          stall;

  int errors = 0;
  int checks = 0;

  filo_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .FILO_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .req_push(req_push), .req_pop(req_pop), .req_data(req_data),
    .gnt(gnt), .resp_val(resp_val), .resp_empty(resp_empty), .resp_data(resp_data),
    .count(count), .stk_wr_en(stk_wr_en), .stk_rd_en(stk_rd_en), .stk_wr_data(stk_wr_data),
    .stk_wr_ready(stk_wr_ready), .stk_rd_data(stk_rd_data), .stk_rd_val(stk_rd_val)
  );

  always #5 clk = ~clk;

  // Behavioural filo stack with registered read.
  logic [DW-1:0] mem [D];
  int len = 0;
  assign stk_wr_ready = (len < D) && !stall;
  always @(posedge clk) begin
    if (reset) begin
      len <= 0; stk_rd_val <= 1'b0; stk_rd_data <= '0;
    end else begin
      stk_rd_val <= 1'b0;
      if (stk_wr_en && len < D) begin
        mem[len] <= stk_wr_data; len <= len + 1;
      end else if (stk_rd_en && len > 0) begin
        stk_rd_data <= mem[len-1]; stk_rd_val <= 1'b1; len <= len - 1;
      end
    end
  end

  typedef struct { int tag; logic [N-1:0] gnt; int count; logic wr_en; logic rd_en; logic [DW-1:0] wr_data; } cyc_t;
  typedef struct { int tag; int req; logic empty; logic [DW-1:0] data; } rsp_t;
  cyc_t exp_cyc[$];
  rsp_t exp_rsp[$];
  logic [DW:0] resp_log[$];
  int cyc = 0;
  int m_ptr = 0;
  int m_count = 0;
  logic [N-1:0] m_gnt_prev = '0;
  logic [DW-1:0] m_stack[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference model: evaluates the arbitration rules on each edge.
  always @(posedge clk) begin : model
    cyc_t e; rsp_t r; int win; int idx; bit full;
    cyc = cyc + 1;
    e.tag = cyc; e.gnt = '0; e.wr_en = 1'b0; e.rd_en = 1'b0; e.wr_data = '0;
    if (reset) begin
      m_ptr = 0; m_count = 0; m_gnt_prev = '0; m_stack.delete(); exp_rsp.delete();
    end else begin
      full = (m_count == D) || !stk_wr_ready;
      win = -1;
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (win < 0 && !m_gnt_prev[idx] && (req_pop[idx] || (req_push[idx] && !full))) win = idx;
      end
      if (win >= 0) begin
        e.gnt[win] = 1'b1;
        m_ptr = (win + 1) % N;
        r.tag = cyc + 1; r.req = win;
        if (req_push[win] && !full) begin
          e.wr_en = 1'b1; e.wr_data = req_data[win*DW +: DW];
          m_stack.push_back(e.wr_data); m_count++;
        end else if (m_count > 0) begin
          e.rd_en = 1'b1; r.empty = 1'b0; r.data = m_stack.pop_back(); m_count--;
          exp_rsp.push_back(r);
        end else begin
          r.empty = 1'b1; r.data = '0; exp_rsp.push_back(r);
        end
      end
      m_gnt_prev = e.gnt;
    end
    e.count = m_count;
    exp_cyc.push_back(e);
  end

  // Monitor: compares per-cycle outputs and every presented response.
  always @(negedge clk) begin : monitor
    cyc_t e; rsp_t r;
    if (exp_cyc.size() > 0) begin
      e = exp_cyc.pop_front();
      chk("cycle_tag", 32'(e.tag), 32'(cyc));
      chk("gnt", 32'(gnt), 32'(e.gnt));
      chk("count", 32'(count), 32'(e.count));
      chk("stk_wr_en", 32'(stk_wr_en), 32'(e.wr_en));
      chk("stk_rd_en", 32'(stk_rd_en), 32'(e.rd_en));
      if (e.wr_en) chk("stk_wr_data", 32'(stk_wr_data), 32'(e.wr_data));
    end
    while (exp_rsp.size() > 0 && exp_rsp[0].tag < cyc) begin
      r = exp_rsp.pop_front();
      chk("resp_missing", 32'(r.tag), 32'(cyc));
    end
    if (resp_val != '0) begin
      if (exp_rsp.size() > 0 && exp_rsp[0].tag == cyc) begin
        r = exp_rsp.pop_front();
        chk("resp_val", 32'(resp_val), 32'(N'(1) << r.req));
        chk("resp_empty", 32'(resp_empty), 32'(r.empty));
        chk("resp_data", 32'(resp_data), 32'(r.data));
        if (!r.empty) chk("stk_rd_val", 32'(stk_rd_val), 32'(1));
      end else begin
        chk("resp_unexpected", 32'(resp_val), 32'(0));
      end
      resp_log.push_back({resp_empty, resp_data});
    end else begin
      chk("resp_data_idle", 32'(resp_data), 32'(0));
    end
  end

  // One cycle; requests granted in this cycle are released after the next edge.
  task automatic step();
    logic [N-1:0] g; logic we;
    @(negedge clk); g = gnt; we = stk_wr_en;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      if (g[i]) begin
        if (we && req_push[i]) req_push[i] = 1'b0;
        else req_pop[i] = 1'b0;
      end
    end
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    while ((req_push | req_pop) != '0 && n < maxc) begin step(); n++; end
    chk("idle_timeout", 32'((req_push | req_pop) != '0), 32'(0));
  endtask

  task automatic push(input int i, input logic [DW-1:0] d);
    req_data[i*DW +: DW] = d; req_push[i] = 1'b1; wait_idle(20);
  endtask

  task automatic pop(input int i);
    req_pop[i] = 1'b1; wait_idle(20);
  endtask

  task automatic do_reset();
    reset = 1'b1; req_push = '0; req_pop = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req_push = '0; req_pop = '0; req_data = '0; stall = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(gnt), 32'(0));
    chk("rst_count", 32'(count), 32'(0));
    chk("rst_wr_en", 32'(stk_wr_en), 32'(0));
    chk("rst_rd_en", 32'(stk_rd_en), 32'(0));
    chk("rst_wr_data", 32'(stk_wr_data), 32'(0));
    chk("rst_resp_val", 32'(resp_val), 32'(0));
    reset = 1'b0;

    // LIFO order through two requesters
    push(0, 8'h11); push(0, 8'h22); push(0, 8'h33);
    chk("t1_count3", 32'(count), 32'(3));
    resp_log.delete();
    pop(1); pop(1); pop(1);
    step(); step();
    chk("t1_nresp", 32'(resp_log.size()), 32'(3));
    chk("t1_resp0", 32'(resp_log[0]), 32'(9'h033));
    chk("t1_resp1", 32'(resp_log[1]), 32'(9'h022));
    chk("t1_resp2", 32'(resp_log[2]), 32'(9'h011));
    chk("t1_count0", 32'(count), 32'(0));

    // Pop on empty stack
    do_reset(); resp_log.delete();
    pop(1); step(); step();
    chk("t2_nresp", 32'(resp_log.size()), 32'(1));
    chk("t2_resp", 32'(resp_log[0]), 32'(9'h100));
    chk("t2_count", 32'(count), 32'(0));

    // Both hold push until full
    do_reset();
    req_data = 16'hB2A1; req_push = '1;
    repeat (12) begin step(); req_push = '1; end
    @(negedge clk);
    chk("t3_count8", 32'(count), 32'(8));
    chk("t3_no_gnt", 32'(gnt), 32'(0));
    chk("t3_no_wr", 32'(stk_wr_en), 32'(0));
    @(posedge clk); #1;

    // Full stack: pop proceeds, waiting push follows
    req_push = 2'b01; req_pop = 2'b10;
    wait_idle(20); step();
    chk("t4_count8", 32'(count), 32'(8));
    req_push = '0;

    // Push and pop together on one requester
    do_reset(); resp_log.delete();
    req_data[0 +: DW] = 8'hA5; req_push[0] = 1'b1; req_pop[0] = 1'b1;
    wait_idle(20); step(); step();
    chk("t5_nresp", 32'(resp_log.size()), 32'(1));
    chk("t5_resp", 32'(resp_log[0]), 32'(9'h0A5));

    // Reset during the grant cycle drops the response
    do_reset();
    push(0, 8'h5A); resp_log.delete();
    req_pop[0] = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1; req_pop = '0;
    repeat (3) begin
      @(negedge clk);
      chk("t6_resp_val", 32'(resp_val), 32'(0));
      chk("t6_wr_en", 32'(stk_wr_en), 32'(0));
    end
    chk("t6_count", 32'(count), 32'(0));
    @(posedge clk); #1 reset = 1'b0;
    chk("t6_nresp", 32'(resp_log.size()), 32'(0));

    // Randomized traffic with stack back-pressure and occasional reset
    repeat (2500) begin
      for (int i = 0; i < N; i++) begin
        if (!req_push[i] && !req_pop[i] && $urandom_range(0, 99) < 40) begin
          int sel;
          sel = $urandom_range(0, 2);
          req_data[i*DW +: DW] = DW'($urandom);
          if (sel != 1) req_push[i] = 1'b1;
          if (sel != 0) req_pop[i] = 1'b1;
        end
      end
      stall = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 399) == 0) begin
        reset = 1'b1; req_push = '0; req_pop = '0;
      end else begin
        reset = 1'b0;
      end
      step();
    end

    reset = 1'b0; stall = 1'b0; req_push = '0; req_pop = '0;
    repeat (4) step();
    chk("resp_leftover", 32'(exp_rsp.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
